// File: rtl/fm_tile_loop_ctrl.sv
// Loop-nest controller for feature-map tile traversal: walks w/h/c/co down-counters
// one step per adv pulse, with diff-layer two-pass handling and layer abort.
module fm_tile_loop_ctrl #(
  parameter int CNT_W   = 8,
  parameter int PE_ROW  = 4,
  parameter int PE_COL  = 4,
  parameter int W_STEP0 = 6,
  parameter int W_STEP1 = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_valid,
  output logic             ctrl_ready,
  output logic             ctrl_finish,
  input  logic             ctrl_abort,
  output logic             aborted,
  input  logic [CNT_W-1:0] w_num_i,
  input  logic [CNT_W-1:0] h_num_i,
  input  logic [CNT_W-1:0] c_num_i,
  input  logic [CNT_W-1:0] co_num_i,
  input  logic [3:0]       shift_bias_i,
  input  logic             kernel_mode_i,
  input  logic             is_diff_i,
  input  logic             is_first_i,
  input  logic             adv,
  output logic             running,
  output logic [CNT_W-1:0] w_num,
  output logic [CNT_W-1:0] h_num,
  output logic [CNT_W-1:0] c_num,
  output logic [CNT_W-1:0] co_num,
  output logic [3:0]       shift_bias,
  output logic             kernel_mode,
  output logic             is_diff,
  output logic             is_first,
  output logic [CNT_W-1:0] count_w,
  output logic [CNT_W-1:0] count_h,
  output logic [CNT_W-1:0] count_c,
  output logic [CNT_W-1:0] count_co,
  output logic             bit_mode,
  output logic             pass,
  output logic             row_par,
  output logic             row_par2,
  output logic [1:0]       count_3,
  output logic             tile_last
);

  // state | meaning
  // IDLE  | waiting for a configuration, counters held at 0
  // RUN   | walking the loop nest, one step per adv
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] W_STEP0_C = CNT_W'(W_STEP0);
  localparam logic [CNT_W-1:0] W_STEP1_C = CNT_W'(W_STEP1);
  localparam logic [CNT_W-1:0] C_STEP1_C = CNT_W'(PE_COL);
  localparam logic [CNT_W-1:0] C_STEP2_C = CNT_W'(2 * PE_COL);
  localparam logic [CNT_W-1:0] PE_ROW_C  = CNT_W'(PE_ROW);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] w_step, c_step;
  logic             last_w, last_h, last_c, last_co;
  logic             accept, zero_dim, done;

  assign accept   = ctrl_valid & ctrl_ready;
  assign zero_dim = (w_num_i == '0) | (h_num_i == '0) | (c_num_i == '0) | (co_num_i == '0);

  assign bit_mode  = is_diff & pass;
  assign w_step    = kernel_mode ? W_STEP1_C : W_STEP0_C;
  assign c_step    = bit_mode ? C_STEP2_C : C_STEP1_C;
  assign last_w    = count_w < w_step;
  assign last_h    = count_h == '0;
  assign last_c    = count_c < c_step;
  assign last_co   = count_co < PE_ROW_C;
  assign tile_last = running & adv & last_w & last_h & last_c;
  assign done      = tile_last & pass & last_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && !zero_dim) state_d = S_RUN;
      S_RUN:  if (ctrl_abort || done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_ready = (state_q == S_IDLE);
    running    = ~ctrl_ready;
  end

  // Completion and abort acknowledges are registered one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_finish <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      ctrl_finish <= (accept & zero_dim) | (done & ~ctrl_abort);
      aborted     <= running & ctrl_abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_num       <= '0;
      h_num       <= '0;
      c_num       <= '0;
      co_num      <= '0;
      shift_bias  <= '0;
      kernel_mode <= 1'b0;
      is_diff     <= 1'b0;
      is_first    <= 1'b0;
    end else if (accept) begin
      w_num       <= w_num_i;
      h_num       <= h_num_i;
      c_num       <= c_num_i;
      co_num      <= co_num_i;
      shift_bias  <= shift_bias_i;
      kernel_mode <= kernel_mode_i;
      is_diff     <= is_diff_i;
      is_first    <= is_first_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_w  <= '0;
      count_h  <= '0;
      count_c  <= '0;
      count_co <= '0;
      pass     <= 1'b0;
      row_par  <= 1'b0;
      row_par2 <= 1'b0;
      count_3  <= '0;
    end else if (accept) begin
      if (zero_dim) begin
        count_w  <= '0;
        count_h  <= '0;
        count_c  <= '0;
        count_co <= '0;
        pass     <= 1'b0;
      end else begin
        count_w  <= w_num_i - ONE_C;
        count_h  <= h_num_i - ONE_C;
        count_c  <= c_num_i - ONE_C;
        count_co <= co_num_i - ONE_C;
        pass     <= ~is_diff_i;
      end
      row_par  <= 1'b0;
      row_par2 <= 1'b0;
      count_3  <= '0;
    end else if (running) begin
      if (ctrl_abort || done) begin
        count_w  <= '0;
        count_h  <= '0;
        count_c  <= '0;
        count_co <= '0;
        pass     <= 1'b0;
        row_par  <= 1'b0;
        row_par2 <= 1'b0;
        count_3  <= '0;
      end else if (adv) begin
        if (!last_w) begin
          count_w <= count_w - w_step;
        end else begin
          count_w <= w_num - ONE_C;
          if (!last_h) begin
            count_h <= count_h - ONE_C;
            row_par <= ~row_par;
            if (!row_par) row_par2 <= ~row_par2;
            if (!kernel_mode || row_par) count_3 <= (count_3 == 2'd2) ? 2'd0 : count_3 + 2'd1;
          end else begin
            count_h <= h_num - ONE_C;
            count_c <= last_c ? c_num - ONE_C : count_c - c_step;
          end
        end
        // Pass toggling uses the pre-edge bit_mode for this tile's c_step above.
        if (tile_last) begin
          if (is_diff) pass <= ~pass;
          if (pass && !last_co) count_co <= count_co - PE_ROW_C;
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_tile_loop_ctrl.sv
// Bench for fm_tile_loop_ctrl: directed traversals plus a table of layer shapes whose
// advance counts are predicted from the loop-count formula and checked by a finish scoreboard.
module tb_fm_tile_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_valid, ctrl_ready, ctrl_finish, ctrl_abort, aborted;
  logic [7:0] w_num_i, h_num_i, c_num_i, co_num_i;
  logic [3:0] shift_bias_i;
  logic       kernel_mode_i, is_diff_i, is_first_i, adv, running;
  logic [7:0] w_num, h_num, c_num, co_num;
  logic [3:0] shift_bias;
  logic       kernel_mode, is_diff, is_first;
  logic [7:0] count_w, count_h, count_c, count_co;
  logic       bit_mode, pass, row_par, row_par2, tile_last;
  logic [1:0] count_3;

  fm_tile_loop_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .ctrl_abort(ctrl_abort), .aborted(aborted),
    .w_num_i(w_num_i), .h_num_i(h_num_i), .c_num_i(c_num_i), .co_num_i(co_num_i),
    .shift_bias_i(shift_bias_i), .kernel_mode_i(kernel_mode_i), .is_diff_i(is_diff_i),
    .is_first_i(is_first_i), .adv(adv), .running(running),
    .w_num(w_num), .h_num(h_num), .c_num(c_num), .co_num(co_num),
    .shift_bias(shift_bias), .kernel_mode(kernel_mode), .is_diff(is_diff), .is_first(is_first),
    .count_w(count_w), .count_h(count_h), .count_c(count_c), .count_co(count_co),
    .bit_mode(bit_mode), .pass(pass), .row_par(row_par), .row_par2(row_par2),
    .count_3(count_3), .tile_last(tile_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fin_q[$];
  int adv_cnt = 0;

  typedef struct {int w; int h; int c; int co; int km; int diff;} layer_t;
  layer_t layers[6] = '{
    '{20, 3,  9, 10, 0, 0},
    '{25, 2, 17,  5, 1, 1},
    '{ 1, 1,  1,  1, 0, 0},
    '{ 1, 1,  1,  1, 0, 1},
    '{255, 1, 1,  1, 0, 0},
    '{ 7, 5,  3,  9, 1, 0}
  };
  int exp_w[4]  = '{11, 5, 11, 5};
  int exp_c[12] = '{7, 7, 7, 7, 3, 3, 3, 3, 7, 7, 7, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Finish scoreboard: each layer pushes its expected advance count when configured.
  always @(negedge clk) begin
    if (ctrl_valid && ctrl_ready) adv_cnt = 0;
    else if (running && adv) adv_cnt++;
    if (ctrl_finish) begin
      if (fin_q.size() == 0) chk("unexp_finish", 1, 0);
      else chk("finish_advs", adv_cnt, fin_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int w, input int h, input int c, input int co, input int km, input int diff);
    w_num_i       = 8'(w);
    h_num_i       = 8'(h);
    c_num_i       = 8'(c);
    co_num_i      = 8'(co);
    kernel_mode_i = km[0];
    is_diff_i     = diff[0];
    shift_bias_i  = 4'hA;
    is_first_i    = 1'b1;
    ctrl_valid    = 1'b1;
    tick();
    ctrl_valid    = 1'b0;
  endtask

  task automatic run_adv(input int budget);
    int n = 0;
    adv = 1'b1;
    while (!ctrl_ready && n < budget) begin
      tick();
      n++;
    end
    adv = 1'b0;
    if (!ctrl_ready) chk("timeout", 0, 1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ctrl_valid = 1'b0; ctrl_abort = 1'b0; adv = 1'b0;
    w_num_i = '0; h_num_i = '0; c_num_i = '0; co_num_i = '0;
    shift_bias_i = '0; kernel_mode_i = 1'b0; is_diff_i = 1'b0; is_first_i = 1'b0;
    tick(); tick();
    chk("rst_ready", ctrl_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_count_w", count_w, 0);
    chk("rst_w_num", w_num, 0);
    chk("rst_pass", pass, 0);
    rst_n = 1'b1;
    tick();

    // Non-diff 12x2x4x4: four advances.
    fin_q.push_back(4);
    cfg(12, 2, 4, 4, 0, 0);
    chk("cfg_w_num", w_num, 12);
    chk("cfg_shift_bias", shift_bias, 10);
    adv = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_count_w", count_w, exp_w[i]);
      chk("t1_tile_last", tile_last, (i == 3));
      if (i == 2) chk("t1_row_par", row_par, 1);
      tick();
    end
    adv = 1'b0;
    chk("t1_finish", ctrl_finish, 1);
    chk("t1_ready", ctrl_ready, 1);
    tick();
    chk("t1_finish_clr", ctrl_finish, 0);

    // Diff version: eight advances over two passes.
    fin_q.push_back(8);
    cfg(12, 2, 4, 4, 0, 1);
    adv = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_pass", pass, (i >= 4));
      chk("t2_bit_mode", bit_mode, (i >= 4));
      tick();
    end
    adv = 1'b0;
    chk("t2_finish", ctrl_finish, 1);
    tick();

    // Diff with c=8: two c sweeps in pass 0, one in pass 1.
    fin_q.push_back(12);
    cfg(12, 2, 8, 4, 0, 1);
    adv = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("t3_count_c", count_c, exp_c[i]);
      tick();
    end
    adv = 1'b0;
    chk("t3_finish", ctrl_finish, 1);
    tick();

    // Two co tiles, kernel_mode=1.
    fin_q.push_back(2);
    cfg(6, 1, 4, 8, 1, 0);
    adv = 1'b1;
    #1;
    chk("t4_count_co0", count_co, 7);
    tick();
    chk("t4_count_co1", count_co, 3);
    tick();
    adv = 1'b0;
    chk("t4_finish", ctrl_finish, 1);
    tick();

    // Abort with a simultaneous adv.
    cfg(12, 2, 4, 4, 0, 0);
    adv = 1'b1;
    tick();
    ctrl_abort = 1'b1;
    tick();
    ctrl_abort = 1'b0;
    adv = 1'b0;
    chk("ab_pulse", aborted, 1);
    chk("ab_no_finish", ctrl_finish, 0);
    chk("ab_count_w", count_w, 0);
    chk("ab_count_h", count_h, 0);
    chk("ab_ready", ctrl_ready, 1);
    tick();
    chk("ab_pulse_clr", aborted, 0);
    ctrl_abort = 1'b1;
    tick();
    ctrl_abort = 1'b0;
    tick();
    chk("ab_idle_ignored", aborted, 0);
    fin_q.push_back(2);
    cfg(6, 1, 4, 8, 1, 0);
    run_adv(50);

    // Zero dimension: immediate finish, never running.
    fin_q.push_back(0);
    cfg(12, 0, 4, 4, 0, 0);
    chk("z_finish", ctrl_finish, 1);
    chk("z_running", running, 0);
    tick();
    chk("z_running2", running, 0);
    chk("z_finish_clr", ctrl_finish, 0);

    // Table of shapes against the loop-count formula.
    foreach (layers[k]) begin
      int ws, nw, nc0, nc1, nco, e;
      ws  = layers[k].km ? 12 : 6;
      nw  = (layers[k].w + ws - 1) / ws;
      nc0 = (layers[k].c + 3) / 4;
      nc1 = (layers[k].c + 7) / 8;
      nco = (layers[k].co + 3) / 4;
      e   = layers[k].diff ? nco * nw * layers[k].h * (nc0 + nc1) : nco * nw * layers[k].h * nc0;
      fin_q.push_back(e);
      cfg(layers[k].w, layers[k].h, layers[k].c, layers[k].co, layers[k].km, layers[k].diff);
      run_adv(1000);
    end

    // Asynchronous reset mid-run.
    cfg(12, 2, 4, 4, 0, 0);
    adv = 1'b1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", ctrl_ready, 1);
    chk("ar_count_w", count_w, 0);
    chk("ar_w_num", w_num, 0);
    chk("ar_shift_bias", shift_bias, 0);
    chk("ar_finish", ctrl_finish, 0);
    chk("ar_aborted", aborted, 0);
    adv = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    chk("sb_drain", fin_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
